// File: rtl/pmm_pkg.sv
// Shared opcodes, PMM memory map indices, FSM states and the command record
// used by the PMM host driver and its command FIFO.
package pmm_pkg;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SIM   = 2'b10;
  localparam logic [1:0] OP_RST   = 2'b11;

  // Word indices inside the PMM; writes at or beyond MEM_WORDS are dropped by the PMM
  localparam int EPS_BEG   = 512;
  localparam int EPS_BLK   = 513;
  localparam int EPS_END   = 514;
  localparam int INIT      = 515;
  localparam int ACCEPT    = 516;
  localparam int MEM_WORDS = 517;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_REL, ST_ERR} state_t;

  typedef struct packed {
    logic [1:0]  op;
    logic [13:0] addr;
    logic [63:0] data;
  } cmd_t;

endpackage

// File: rtl/pmm_host_driver_if.sv
// PMM command/data bus: the driver is the master, the PMM core is the slave.
interface pmm_host_driver_if;
  logic [63:0] INP_DATA;
  logic [15:0] INP_CONTROL;
  logic        DATA_VALID;
  logic        READY_STATUS;
  logic        ACCEPTED_STATUS;

  modport master (output INP_DATA, INP_CONTROL, DATA_VALID,
                  input  READY_STATUS, ACCEPTED_STATUS);
  modport slave  (input  INP_DATA, INP_CONTROL, DATA_VALID,
                  output READY_STATUS, ACCEPTED_STATUS);
endinterface

// File: rtl/pmm_cmd_fifo.sv
// Synchronous command FIFO with first-word fall-through read; pointers carry
// one extra wrap bit so full and empty are distinguishable.
module pmm_cmd_fifo
  import pmm_pkg::*;
#(
  parameter int CMD_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  cmd_t wr_cmd,
  input  logic pop,
  output cmd_t rd_cmd,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(CMD_DEPTH);

  cmd_t           mem [CMD_DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_cmd = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wr_cmd;
  end

endmodule

// File: rtl/pmm_host_driver.sv
// Initiator for the PMM four-phase DATA_VALID/READY_STATUS handshake: queues
// upstream commands, issues them one at a time and reports simulate results.
module pmm_host_driver
  import pmm_pkg::*;
#(
  parameter int CMD_DEPTH = 4,
  parameter int POS_W     = 32,
  parameter int TIMEOUT   = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [13:0]       cmd_addr,
  input  logic [63:0]       cmd_data,
  pmm_host_driver_if.master bus,
  output logic              match_valid,
  output logic              match_hit,
  output logic [POS_W-1:0]  match_pos,
  output logic              busy,
  output logic              err_timeout,
  input  logic              err_clr
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  state_t             state, state_nxt;
  cmd_t               head;
  logic               fifo_full, fifo_empty;
  logic               pop, load, hs_done, timeout_hit;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [POS_W-1:0]   char_cnt;
  logic [63:0]        inp_data;
  logic [15:0]        inp_control;
  logic               data_valid;

  pmm_cmd_fifo #(.CMD_DEPTH(CMD_DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (cmd_valid),
    .wr_cmd ('{op: cmd_op, addr: cmd_addr, data: cmd_data}),
    .pop    (pop),
    .rd_cmd (head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign cmd_ready       = !fifo_full;
  assign busy            = (state != ST_IDLE) || !fifo_empty;
  assign bus.INP_DATA    = inp_data;
  assign bus.INP_CONTROL = inp_control;
  assign bus.DATA_VALID  = data_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    pop         = 1'b0;
    load        = 1'b0;
    hs_done     = 1'b0;
    timeout_hit = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head.op != OP_NOP) begin
            load      = 1'b1;
            state_nxt = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (bus.READY_STATUS) begin
          hs_done   = 1'b1;
          state_nxt = ST_REL;
        end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_nxt   = ST_ERR;
        end
      end
      ST_REL: begin
        if (!bus.READY_STATUS) begin
          state_nxt = ST_IDLE;
        end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_nxt   = ST_ERR;
        end
      end
      ST_ERR: begin
        if (err_clr) state_nxt = ST_REL;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Bus registers, match reporting, character counter and phase timeout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inp_data    <= '0;
      inp_control <= '0;
      data_valid  <= 1'b0;
      match_valid <= 1'b0;
      match_hit   <= 1'b0;
      match_pos   <= '0;
      char_cnt    <= '0;
      err_timeout <= 1'b0;
      tmo_cnt     <= '0;
    end else begin
      match_valid <= 1'b0;
      if (load) begin
        inp_data    <= head.data;
        inp_control <= {head.op, head.addr};
        data_valid  <= 1'b1;
      end
      if (hs_done) begin
        data_valid <= 1'b0;
        if (inp_control[15:14] == OP_SIM) begin
          match_valid <= 1'b1;
          match_hit   <= bus.ACCEPTED_STATUS;
          match_pos   <= char_cnt;
          char_cnt    <= char_cnt + POS_W'(1);
        end else if (inp_control[15:14] == OP_RST) begin
          char_cnt <= '0;
        end
      end
      if (err_clr) err_timeout <= 1'b0;
      if (timeout_hit) begin
        data_valid  <= 1'b0;
        err_timeout <= 1'b1;
      end
      if (state_nxt != state)                      tmo_cnt <= '0;
      else if (state == ST_REQ || state == ST_REL) tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

endmodule

// File: tb/tb_pmm_host_driver.sv
// Directed bench for pmm_host_driver: the bench plays the PMM side of the
// handshake by hand and compares against hand-computed values.
module tb_pmm_host_driver;
  import pmm_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [13:0] cmd_addr = '0;
  logic [63:0] cmd_data = '0;
  logic        match_valid;
  logic        match_hit;
  logic [31:0] match_pos;
  logic        busy;
  logic        err_timeout;
  logic        err_clr = 1'b0;

  int total = 0;
  int bad   = 0;

  logic        hit_q[$];
  logic [31:0] pos_q[$];

  pmm_host_driver_if bus();

  pmm_host_driver #(.CMD_DEPTH(4), .POS_W(32), .TIMEOUT(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_addr    (cmd_addr),
    .cmd_data    (cmd_data),
    .bus         (bus),
    .match_valid (match_valid),
    .match_hit   (match_hit),
    .match_pos   (match_pos),
    .busy        (busy),
    .err_timeout (err_timeout),
    .err_clr     (err_clr)
  );

  always #5 clk = ~clk;

  // Record every match pulse so scenarios can inspect the sequence afterwards
  always @(posedge clk) begin
    #1;
    if (!rst && match_valid) begin
      hit_q.push_back(match_hit);
      pos_q.push_back(match_pos);
    end
  end

  task automatic push_cmd(input logic [1:0] op, input logic [13:0] addr,
                          input logic [63:0] data, output bit ok);
    int n = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    if (!cmd_ready) begin
      cmd_valid = 1'b0;
      ok = 1'b0;
    end else begin
      @(negedge clk);
      cmd_valid = 1'b0;
      ok = 1'b1;
    end
  endtask

  task automatic wait_dv(output bit ok);
    int n = 0;
    while (!bus.DATA_VALID && n < 50) begin @(negedge clk); n++; end
    ok = bus.DATA_VALID;
  endtask

  task automatic pmm_ack(input logic accept);
    bus.READY_STATUS = 1'b1; bus.ACCEPTED_STATUS = accept;
    @(negedge clk);
    bus.READY_STATUS = 1'b0; bus.ACCEPTED_STATUS = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    total++; if (bus.DATA_VALID !== 1'b0) begin bad++; $display("[TB] FAIL reset_dv got=%0b exp=0", bus.DATA_VALID); end
    total++; if (bus.INP_DATA !== 64'h0) begin bad++; $display("[TB] FAIL reset_data got=%0h exp=0", bus.INP_DATA); end
    total++; if (bus.INP_CONTROL !== 16'h0) begin bad++; $display("[TB] FAIL reset_ctrl got=%0h exp=0", bus.INP_CONTROL); end
    total++; if (match_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_mv got=%0b exp=0", match_valid); end
    total++; if (match_hit !== 1'b0) begin bad++; $display("[TB] FAIL reset_hit got=%0b exp=0", match_hit); end
    total++; if (match_pos !== 32'h0) begin bad++; $display("[TB] FAIL reset_pos got=%0d exp=0", match_pos); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%0b exp=0", busy); end
    total++; if (err_timeout !== 1'b0) begin bad++; $display("[TB] FAIL reset_err got=%0b exp=0", err_timeout); end
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready got=%0b exp=1", cmd_ready); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mask_write;
    bit ok;
    hit_q.delete(); pos_q.delete();
    push_cmd(OP_WRITE, 14'h1020, 64'hA5, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL mw_push got=%0b exp=1", ok); end
    total++; if (bus.DATA_VALID !== 1'b0) begin bad++; $display("[TB] FAIL mw_latency_early got=%0b exp=0", bus.DATA_VALID); end
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL mw_busy got=%0b exp=1", busy); end
    @(negedge clk);
    total++; if (bus.DATA_VALID !== 1'b1) begin bad++; $display("[TB] FAIL mw_dv got=%0b exp=1", bus.DATA_VALID); end
    for (int i = 0; i < 3; i++) begin
      total++; if (bus.INP_CONTROL !== 16'h5020) begin bad++; $display("[TB] FAIL mw_ctrl got=%0h exp=5020", bus.INP_CONTROL); end
      total++; if (bus.INP_DATA !== 64'hA5) begin bad++; $display("[TB] FAIL mw_data got=%0h exp=a5", bus.INP_DATA); end
      @(negedge clk);
    end
    pmm_ack(1'b0);
    total++; if (bus.DATA_VALID !== 1'b0) begin bad++; $display("[TB] FAIL mw_dv_done got=%0b exp=0", bus.DATA_VALID); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL mw_busy_done got=%0b exp=0", busy); end
    total++; if (hit_q.size() !== 0) begin bad++; $display("[TB] FAIL mw_no_match got=%0d exp=0", hit_q.size()); end
  endtask

  task automatic test_sim_sequence;
    bit ok;
    hit_q.delete(); pos_q.delete();
    push_cmd(OP_RST, 14'h0, 64'h0, ok);
    push_cmd(OP_SIM, 14'h0, 64'h61, ok);
    push_cmd(OP_SIM, 14'h0, 64'h62, ok);
    push_cmd(OP_SIM, 14'h0, 64'h63, ok);
    for (int i = 0; i < 4; i++) begin
      wait_dv(ok);
      total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL sim_dv%0d got=%0b exp=1", i, ok); end
      if (i == 1) begin
        total++; if (bus.INP_CONTROL !== 16'h8000) begin bad++; $display("[TB] FAIL sim_ctrl got=%0h exp=8000", bus.INP_CONTROL); end
      end
      if (i == 3) begin
        total++; if (bus.INP_DATA !== 64'h63) begin bad++; $display("[TB] FAIL sim_char_c got=%0h exp=63", bus.INP_DATA); end
      end
      pmm_ack(i == 3);
    end
    @(negedge clk);
    total++; if (pos_q.size() !== 3) begin bad++; $display("[TB] FAIL sim_pulses got=%0d exp=3", pos_q.size()); end
    if (pos_q.size() == 3) begin
      for (int k = 0; k < 3; k++) begin
        total++; if (pos_q[k] !== 32'(k)) begin bad++; $display("[TB] FAIL sim_pos%0d got=%0d exp=%0d", k, pos_q[k], k); end
        total++; if (hit_q[k] !== (k == 2)) begin bad++; $display("[TB] FAIL sim_hit%0d got=%0b exp=%0b", k, hit_q[k], k == 2); end
      end
    end
    total++; if (match_hit !== 1'b1) begin bad++; $display("[TB] FAIL sim_hit_hold got=%0b exp=1", match_hit); end
    total++; if (match_pos !== 32'd2) begin bad++; $display("[TB] FAIL sim_pos_hold got=%0d exp=2", match_pos); end
  endtask

  task automatic test_char_reset;
    bit ok;
    hit_q.delete(); pos_q.delete();
    push_cmd(OP_SIM, 14'h0, 64'h78, ok);
    push_cmd(OP_SIM, 14'h0, 64'h79, ok);
    push_cmd(OP_RST, 14'h0, 64'h0, ok);
    push_cmd(OP_SIM, 14'h0, 64'h7A, ok);
    for (int i = 0; i < 4; i++) begin
      wait_dv(ok);
      total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL cr_dv%0d got=%0b exp=1", i, ok); end
      pmm_ack(1'b0);
    end
    @(negedge clk);
    total++; if (pos_q.size() !== 3) begin bad++; $display("[TB] FAIL cr_pulses got=%0d exp=3", pos_q.size()); end
    if (pos_q.size() == 3) begin
      total++; if (pos_q[0] !== 32'd3) begin bad++; $display("[TB] FAIL cr_pos0 got=%0d exp=3", pos_q[0]); end
      total++; if (pos_q[1] !== 32'd4) begin bad++; $display("[TB] FAIL cr_pos1 got=%0d exp=4", pos_q[1]); end
      total++; if (pos_q[2] !== 32'd0) begin bad++; $display("[TB] FAIL cr_pos2 got=%0d exp=0", pos_q[2]); end
    end
    total++; if (match_pos !== 32'd0) begin bad++; $display("[TB] FAIL cr_pos_hold got=%0d exp=0", match_pos); end
  endtask

  task automatic test_timeout;
    bit ok;
    int cnt = 0;
    hit_q.delete(); pos_q.delete();
    push_cmd(OP_WRITE, 14'h5, 64'h1, ok);
    push_cmd(OP_WRITE, 14'h6, 64'h2, ok);
    wait_dv(ok);
    total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL to_dv got=%0b exp=1", ok); end
    while (bus.DATA_VALID && cnt < 100) begin cnt++; @(negedge clk); end
    total++; if (cnt !== 16) begin bad++; $display("[TB] FAIL to_req_cycles got=%0d exp=16", cnt); end
    total++; if (err_timeout !== 1'b1) begin bad++; $display("[TB] FAIL to_err got=%0b exp=1", err_timeout); end
    repeat (3) @(negedge clk);
    total++; if (bus.DATA_VALID !== 1'b0) begin bad++; $display("[TB] FAIL to_err_idle got=%0b exp=0", bus.DATA_VALID); end
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL to_busy got=%0b exp=1", busy); end
    total++; if (err_timeout !== 1'b1) begin bad++; $display("[TB] FAIL to_sticky got=%0b exp=1", err_timeout); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    total++; if (err_timeout !== 1'b0) begin bad++; $display("[TB] FAIL to_clr got=%0b exp=0", err_timeout); end
    wait_dv(ok);
    total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL to_resume got=%0b exp=1", ok); end
    total++; if (bus.INP_CONTROL !== 16'h4006) begin bad++; $display("[TB] FAIL to_next_ctrl got=%0h exp=4006", bus.INP_CONTROL); end
    total++; if (bus.INP_DATA !== 64'h2) begin bad++; $display("[TB] FAIL to_next_data got=%0h exp=2", bus.INP_DATA); end
    pmm_ack(1'b0);
    total++; if (hit_q.size() !== 0) begin bad++; $display("[TB] FAIL to_no_match got=%0d exp=0", hit_q.size()); end
  endtask

  task automatic test_back_to_back;
    bit ok;
    bit ok6;
    for (int i = 0; i < 5; i++) begin
      push_cmd(OP_WRITE, 14'(16 + i), 64'(i), ok);
      total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL bp_push%0d got=%0b exp=1", i, ok); end
    end
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_full got=%0b exp=0", cmd_ready); end
    total++; if (bus.INP_CONTROL !== 16'h4010) begin bad++; $display("[TB] FAIL bp_head got=%0h exp=4010", bus.INP_CONTROL); end
    fork
      push_cmd(OP_WRITE, 14'h15, 64'h5, ok6);
      begin
        repeat (3) @(negedge clk);
        total++; if (cmd_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_still_full got=%0b exp=0", cmd_ready); end
        pmm_ack(1'b0);
      end
    join
    total++; if (ok6 !== 1'b1) begin bad++; $display("[TB] FAIL bp_push_after_pop got=%0b exp=1", ok6); end
    for (int i = 1; i < 6; i++) begin
      wait_dv(ok);
      total++; if (bus.INP_CONTROL !== 16'h4010 + 16'(i)) begin bad++; $display("[TB] FAIL bp_order%0d got=%0h exp=%0h", i, bus.INP_CONTROL, 16'h4010 + 16'(i)); end
      pmm_ack(1'b0);
    end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL bp_drained got=%0b exp=0", busy); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    push_cmd(OP_SIM, 14'h0, 64'h41, ok);
    push_cmd(OP_SIM, 14'h0, 64'h42, ok);
    wait_dv(ok);
    total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL rm_dv got=%0b exp=1", ok); end
    rst = 1'b1;
    #1;
    total++; if (bus.DATA_VALID !== 1'b0) begin bad++; $display("[TB] FAIL rm_dv_drop got=%0b exp=0", bus.DATA_VALID); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rm_busy got=%0b exp=0", busy); end
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("[TB] FAIL rm_ready got=%0b exp=1", cmd_ready); end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    total++; if (bus.DATA_VALID !== 1'b0) begin bad++; $display("[TB] FAIL rm_discard got=%0b exp=0", bus.DATA_VALID); end
    hit_q.delete(); pos_q.delete();
    push_cmd(OP_SIM, 14'h0, 64'h43, ok);
    wait_dv(ok);
    pmm_ack(1'b1);
    @(negedge clk);
    total++; if (pos_q.size() !== 1) begin bad++; $display("[TB] FAIL rm_pulses got=%0d exp=1", pos_q.size()); end
    if (pos_q.size() == 1) begin
      total++; if (pos_q[0] !== 32'd0) begin bad++; $display("[TB] FAIL rm_charcnt got=%0d exp=0", pos_q[0]); end
      total++; if (hit_q[0] !== 1'b1) begin bad++; $display("[TB] FAIL rm_hit got=%0b exp=1", hit_q[0]); end
    end
  endtask

  initial begin
    bus.READY_STATUS    = 1'b0;
    bus.ACCEPTED_STATUS = 1'b0;
    test_reset();
    test_mask_write();
    test_sim_sequence();
    test_char_reset();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("[TB] FAIL watchdog got=running exp=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
